// File: rtl/rx_huge_page_sched.sv
// RX huge page scheduler: ping-pongs two driver pages and carves QW-aligned write regions out of them.
// Optional idle-timeout page close is built when RX_PAGE_TIMEOUT_EN is defined.
module rx_huge_page_sched #(
  parameter int PAGE_QW_W       = 18,
  parameter int LEN_W           = 11,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                 trn_clk,
  input  logic                 reset,
  input  logic [63:0]          huge_page_addr_1,
  input  logic [63:0]          huge_page_addr_2,
  input  logic                 huge_page_status_1,
  input  logic                 huge_page_status_2,
  output logic                 huge_page_free_1,
  output logic                 huge_page_free_2,
  input  logic                 alloc_req,
  input  logic [LEN_W-1:0]     alloc_len_qw,
  output logic                 alloc_gnt,
  output logic [63:0]          alloc_addr,
  input  logic                 alloc_done,
  output logic                 page_close_vld,
  output logic                 page_close_id,
  output logic [PAGE_QW_W:0]   page_close_qw
);

  localparam int OFF_W = PAGE_QW_W + 1;
  localparam int FIT_W = PAGE_QW_W + 2;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [FIT_W-1:0] PAGE_QW = FIT_W'(1) << PAGE_QW_W;
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

  // Bit 2 selects the page, bits 1:0 the phase, so page-generic moves are a cast.
  typedef enum logic [2:0] {
    WAIT1 = 3'd0, FILL1 = 3'd1, DRAIN1 = 3'd2, CLOSE1 = 3'd3,
    WAIT2 = 3'd4, FILL2 = 3'd5, DRAIN2 = 3'd6, CLOSE2 = 3'd7
  } state_t;

  state_t             state;
  logic [OFF_W-1:0]   offset;
  logic [OUT_W-1:0]   outstanding;

  logic               page_sel;
  logic [63:0]        base;
  logic               status;
  logic               in_fill;
  logic [FIT_W-1:0]   fit_end;
  logic               fits;
  logic               page_full;
  logic               req_ok;
  logic               grant;
  logic               overflow;
  logic               done_dec;
  logic               tmo;
  logic [63:0]        off_bytes;

  assign page_sel  = state[2];
  assign base      = page_sel ? huge_page_addr_2 : huge_page_addr_1;
  assign status    = page_sel ? huge_page_status_2 : huge_page_status_1;
  assign in_fill   = (state == FILL1) || (state == FILL2);
  assign fit_end   = {1'b0, offset} + {{(FIT_W-LEN_W){1'b0}}, alloc_len_qw};
  assign fits      = (fit_end <= PAGE_QW);
  assign page_full = ({1'b0, offset} == PAGE_QW);
  // The cycle alloc_gnt is high still shows the just-served request, so it is neither granted nor overflowed.
  assign req_ok    = in_fill && alloc_req && !alloc_gnt && !page_full;
  assign grant     = req_ok && fits && (outstanding < MAX_OUT);
  assign overflow  = req_ok && !fits;
  assign done_dec  = alloc_done && (outstanding != '0);
  assign off_bytes = {{(61-OFF_W){1'b0}}, offset, 3'b000};

`ifdef RX_PAGE_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_cnt;

  assign tmo = in_fill && (offset != '0) && !grant && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge trn_clk) begin
    if (reset || !in_fill || grant || tmo)
      idle_cnt <= '0;
    else if (offset != '0)
      idle_cnt <= idle_cnt + 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign tmo = 1'b0;
`endif

  always_ff @(posedge trn_clk) begin
    if (reset) begin
      state            <= WAIT1;
      offset           <= '0;
      outstanding      <= '0;
      alloc_gnt        <= 1'b0;
      alloc_addr       <= '0;
      huge_page_free_1 <= 1'b0;
      huge_page_free_2 <= 1'b0;
      page_close_vld   <= 1'b0;
      page_close_id    <= 1'b0;
      page_close_qw    <= '0;
    end else begin
      alloc_gnt        <= 1'b0;
      huge_page_free_1 <= 1'b0;
      huge_page_free_2 <= 1'b0;
      page_close_vld   <= 1'b0;

      case ({grant, done_dec})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase

      case (state)
        WAIT1, WAIT2: begin
          if (status) begin
            state  <= state_t'({page_sel, 2'd1});
            offset <= '0;
          end
        end
        FILL1, FILL2: begin
          if (page_full || overflow || tmo) begin
            state <= state_t'({page_sel, 2'd2});
          end else if (grant) begin
            alloc_gnt  <= 1'b1;
            alloc_addr <= base + off_bytes;
            offset     <= fit_end[OFF_W-1:0];
          end
        end
        DRAIN1, DRAIN2: begin
          if (outstanding == '0) begin
            state            <= state_t'({page_sel, 2'd3});
            huge_page_free_1 <= !page_sel;
            huge_page_free_2 <= page_sel;
            page_close_vld   <= 1'b1;
            page_close_id    <= page_sel;
            page_close_qw    <= offset;
          end
        end
        default: begin
          state <= state_t'({!page_sel, 2'd0});
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_huge_page_sched.sv
// Directed bench for rx_huge_page_sched with a 64-QW page and two outstanding writes.
module tb_rx_huge_page_sched;

  localparam int PAGE_QW_W = 6;
  localparam int LEN_W     = 6;
  localparam logic [63:0] BASE1 = 64'h0000_1000_0000_0000;
  localparam logic [63:0] BASE2 = 64'h0000_2000_0000_0000;

  logic               trn_clk = 1'b0;
  logic               reset;
  logic [63:0]        huge_page_addr_1, huge_page_addr_2;
  logic               huge_page_status_1, huge_page_status_2;
  logic               huge_page_free_1, huge_page_free_2;
  logic               alloc_req;
  logic [LEN_W-1:0]   alloc_len_qw;
  logic               alloc_gnt;
  logic [63:0]        alloc_addr;
  logic               alloc_done;
  logic               page_close_vld;
  logic               page_close_id;
  logic [PAGE_QW_W:0] page_close_qw;

  int n_chk = 0, n_fail = 0;
  int free1_cnt = 0, free2_cnt = 0, gnt_cnt = 0, bad_coinc = 0;
  logic [PAGE_QW_W:0] last_qw = '0;
  logic               last_id = 1'b0;

  logic               got;
  logic [63:0]        gaddr;
  int                 lat;

  rx_huge_page_sched #(
    .PAGE_QW_W(PAGE_QW_W), .LEN_W(LEN_W), .MAX_OUTSTANDING(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .trn_clk(trn_clk), .reset(reset),
    .huge_page_addr_1(huge_page_addr_1), .huge_page_addr_2(huge_page_addr_2),
    .huge_page_status_1(huge_page_status_1), .huge_page_status_2(huge_page_status_2),
    .huge_page_free_1(huge_page_free_1), .huge_page_free_2(huge_page_free_2),
    .alloc_req(alloc_req), .alloc_len_qw(alloc_len_qw),
    .alloc_gnt(alloc_gnt), .alloc_addr(alloc_addr), .alloc_done(alloc_done),
    .page_close_vld(page_close_vld), .page_close_id(page_close_id),
    .page_close_qw(page_close_qw)
  );

  always #5 trn_clk = ~trn_clk;

  always @(posedge trn_clk) begin
    #1;
    if (huge_page_free_1) free1_cnt++;
    if (huge_page_free_2) free2_cnt++;
    if (alloc_gnt) gnt_cnt++;
    if (page_close_vld) begin
      last_qw = page_close_qw;
      last_id = page_close_id;
    end
    if ((huge_page_free_1 || huge_page_free_2) != page_close_vld) bad_coinc++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for alloc_gnt with alloc_req already raised; drops the request once granted.
  task automatic wait_gnt(input int max_cyc);
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge trn_clk);
      if (alloc_gnt) begin
        got = 1'b1;
        gaddr = alloc_addr;
        lat = i;
        alloc_req = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_req(input string tag, input int len, input logic [63:0] exp_addr);
    @(negedge trn_clk);
    alloc_req = 1'b1;
    alloc_len_qw = LEN_W'(len);
    wait_gnt(5);
    chk({tag, "_got"}, 64'(got), 64'd1);
    if (got) chk(tag, gaddr, exp_addr);
  endtask

  task automatic hold_req(input string tag, input int len);
    @(negedge trn_clk);
    alloc_req = 1'b1;
    alloc_len_qw = LEN_W'(len);
    wait_gnt(4);
    chk(tag, 64'(got), 64'd0);
  endtask

  task automatic pulse_done();
    @(negedge trn_clk);
    alloc_done = 1'b1;
    @(negedge trn_clk);
    alloc_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    huge_page_addr_1 = BASE1;
    huge_page_addr_2 = BASE2;
    huge_page_status_1 = 1'b0;
    huge_page_status_2 = 1'b0;
    alloc_req = 1'b0;
    alloc_len_qw = '0;
    alloc_done = 1'b0;
    repeat (3) @(negedge trn_clk);
    chk("rst_gnt", 64'(alloc_gnt), 64'd0);
    chk("rst_addr", alloc_addr, 64'd0);
    chk("rst_free", 64'({huge_page_free_1, huge_page_free_2, page_close_vld}), 64'd0);
    chk("rst_qw", 64'(page_close_qw), 64'd0);
    reset = 1'b0;

    // No grant while page 1 is still driver-owned
    hold_req("wait1_hold", 10);
    huge_page_status_1 = 1'b1;
    wait_gnt(4);
    chk("first_got", 64'(got), 64'd1);
    chk("first_addr", gaddr, BASE1);
    do_req("second", 4, BASE1 + 64'h50);
    chk("second_lat", 64'(lat), 64'd1);
    pulse_done();
    pulse_done();

    // Fill to 60 QW, then an 8-QW request overflows and is served from page 2
    do_req("fill60", 46, BASE1 + 64'h70);
    hold_req("ovf_hold", 8);
    chk("ovf_nofree", 64'(free1_cnt), 64'd0);
    huge_page_status_2 = 1'b1;
    pulse_done();
    wait_gnt(10);
    chk("p2_got", 64'(got), 64'd1);
    chk("p2_addr", gaddr, BASE2);
    chk("p1_free", 64'(free1_cnt), 64'd1);
    chk("p1_qw", 64'(last_qw), 64'd60);
    chk("p1_id", 64'(last_id), 64'd0);
    huge_page_status_1 = 1'b0;

    // Exact fill with two outstanding: close waits for the second done
    do_req("exact", 56, BASE2 + 64'h40);
    repeat (5) @(negedge trn_clk);
    chk("exact_hold0", 64'(free2_cnt), 64'd0);
    pulse_done();
    repeat (4) @(negedge trn_clk);
    chk("exact_hold1", 64'(free2_cnt), 64'd0);
    pulse_done();
    repeat (4) @(negedge trn_clk);
    chk("p2_free", 64'(free2_cnt), 64'd1);
    chk("p2_qw", 64'(last_qw), 64'd64);
    chk("p2_id", 64'(last_id), 64'd1);
    huge_page_status_2 = 1'b0;

    // Page 1 reuse waits for the driver to hand it back
    hold_req("reuse_hold", 3);
    huge_page_status_1 = 1'b1;
    wait_gnt(5);
    chk("reuse_got", 64'(got), 64'd1);
    chk("reuse_addr", gaddr, BASE1);
    pulse_done();

    // Outstanding limit of 2
    do_req("a", 1, BASE1 + 64'h18);
    do_req("b", 1, BASE1 + 64'h20);
    hold_req("max_hold", 1);
    pulse_done();
    wait_gnt(4);
    chk("c_got", 64'(got), 64'd1);
    chk("c_addr", gaddr, BASE1 + 64'h28);
    pulse_done();
    pulse_done();
    do_req("d", 1, BASE1 + 64'h30);
    do_req("e", 1, BASE1 + 64'h38);
    // done in the cycle e's grant is visible frees a slot for f
    alloc_done = 1'b1;
    alloc_req = 1'b1;
    alloc_len_qw = LEN_W'(1);
    @(negedge trn_clk);
    alloc_done = 1'b0;
    wait_gnt(3);
    chk("f_got", 64'(got), 64'd1);
    chk("f_addr", gaddr, BASE1 + 64'h40);

    // grant decision and done on the same edge leave the count unchanged
    pulse_done();
    alloc_req = 1'b1;
    alloc_done = 1'b1;
    @(negedge trn_clk);
    alloc_done = 1'b0;
    chk("g_gnt", 64'(alloc_gnt), 64'd1);
    chk("g_addr", alloc_addr, BASE1 + 64'h48);
    alloc_req = 1'b0;
    do_req("h", 1, BASE1 + 64'h50);
    hold_req("max_hold2", 1);
    pulse_done();
    wait_gnt(4);
    chk("i_addr", gaddr, BASE1 + 64'h58);

    // extra done at zero saturates
    pulse_done();
    pulse_done();
    pulse_done();
    do_req("j", 1, BASE1 + 64'h60);
    do_req("k", 1, BASE1 + 64'h68);
    pulse_done();
    pulse_done();

    repeat (40) @(negedge trn_clk);
`ifdef RX_PAGE_TIMEOUT_EN
    chk("timeout_free", 64'(free1_cnt), 64'd2);
    chk("timeout_qw", 64'(last_qw), 64'd14);
`else
    chk("no_timeout", 64'(free1_cnt), 64'd1);
`endif

    // Reset mid-page: no free pulse, page restarts at offset 0
    reset = 1'b1;
    repeat (2) @(negedge trn_clk);
    chk("rst2_addr", alloc_addr, 64'd0);
    chk("rst2_qw", 64'(page_close_qw), 64'd0);
    reset = 1'b0;
    do_req("post_rst", 5, BASE1);
`ifdef RX_PAGE_TIMEOUT_EN
    chk("rst2_free1", 64'(free1_cnt), 64'd2);
`else
    chk("rst2_free1", 64'(free1_cnt), 64'd1);
`endif
    chk("free2_total", 64'(free2_cnt), 64'd1);
    chk("gnt_total", 64'(gnt_cnt), 64'd18);
    chk("close_coinc", 64'(bad_coinc), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
